// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and main memory.
// Read hits return data combinationally; misses refill a whole line while stall_o holds the pipeline.
`timescale 1ns/1ps
module dcache_direct #(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
);

    localparam int IW = $clog2(SETS);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int TW = 32 - IW - OW - 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t          state_r;
    logic [SETS-1:0] valid_r;
    logic [TW-1:0]   tag_r  [SETS];
    logic [31:0]     data_r [SETS][LINE_WORDS];
    logic [OW-1:0]   beat_r;
    logic            replay_r;
    logic [31:0]     hit_cnt_r;
    logic [31:0]     miss_cnt_r;

    logic [OW-1:0]   word_s;
    logic [IW-1:0]   index_s;
    logic [TW-1:0]   tag_s;
    logic            hit_s;
    logic            last_beat_s;
    logic            xfer_s;
    logic            unused_s;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    assign word_s      = addr_i[OW+1:2];
    assign index_s     = addr_i[OW+IW+1:OW+2];
    assign tag_s       = addr_i[31:OW+IW+2];
    assign hit_s       = valid_r[index_s] && (tag_r[index_s] == tag_s);
    assign last_beat_s = (beat_r == OW'(LINE_WORDS - 1));
    assign xfer_s      = mem_req_o && mem_ready_i;
    assign unused_s    = ^addr_i[1:0];
    assign hit_cnt_o   = hit_cnt_r;
    assign miss_cnt_o  = miss_cnt_r;

    // Pipeline and memory-port outputs decoded from the FSM state and the held request.
    always_comb begin
        rdata_o     = data_r[index_s][word_s];
        stall_o     = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = {addr_i[31:2], 2'b00};
        mem_wdata_o = wdata_i;
        mem_be_o    = 4'hF;
        case (state_r)
            ST_IDLE: begin
                stall_o = req_i && (we_i || !hit_s);
            end
            ST_REFILL: begin
                stall_o    = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = {addr_i[31:OW+2], beat_r, 2'b00};
            end
            ST_WRITE: begin
                stall_o   = 1'b1;
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                mem_be_o  = be_i;
            end
            ST_DONE: begin
                stall_o = 1'b0;
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

    // FSM, line storage and performance counters; reset abandons any memory transaction in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            valid_r    <= '0;
            beat_r     <= '0;
            replay_r   <= 1'b0;
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    replay_r <= 1'b0;
                    if (req_i) begin
                        if (we_i) begin
                            state_r <= ST_WRITE;
                        end else if (hit_s) begin
                            // The first hit after a refill is the replayed miss, already counted.
                            if (!replay_r) begin
                                hit_cnt_r <= sat_inc(hit_cnt_r);
                            end
                        end else begin
                            state_r          <= ST_REFILL;
                            beat_r           <= '0;
                            valid_r[index_s] <= 1'b0;
                            miss_cnt_r       <= sat_inc(miss_cnt_r);
                        end
                    end
                end
                ST_REFILL: begin
                    if (xfer_s) begin
                        data_r[index_s][beat_r] <= mem_rdata_i;
                        beat_r                  <= beat_r + 1'b1;
                        if (last_beat_s) begin
                            valid_r[index_s] <= 1'b1;
                            tag_r[index_s]   <= tag_s;
                            replay_r         <= 1'b1;
                            state_r          <= ST_IDLE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (xfer_s) begin
                        if (hit_s) begin
                            data_r[index_s][word_s] <= merge_bytes(data_r[index_s][word_s], wdata_i, be_i);
                        end
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_direct.sv
// Scoreboard bench for dcache_direct: a memory model answers the port, expected
// transfers and load data are queued at issue and compared as the DUT produces them.
`timescale 1ns/1ps
module tb_dcache_direct;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] wdata_i = 32'd0;
    logic [3:0]  be_i = 4'h0;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ready_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'd0;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    int checks = 0;
    int errors = 0;
    bit rand_ready = 1'b0;

    logic [36:0] xfer_q [$];
    logic [31:0] rd_q [$];
    logic [31:0] mem_m [logic [31:0]];

    logic        prev_wait = 1'b0;
    logic [67:0] prev_bus = '0;
    logic [36:0] resp_exp;
    logic [31:0] resp_w;

    dcache_direct #(.SETS(16), .LINE_WORDS(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .rdata_o(rdata_o), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_ready_i(mem_ready_i),
        .mem_rdata_i(mem_rdata_i), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // Memory responder: drives ready/data mid-cycle, checks each transfer against the queue.
    always begin
        @(negedge clk);
        #1;
        mem_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        mem_rdata_i = mem_rd(mem_addr_o);
        if (rst_i) begin
            prev_wait = 1'b0;
        end else if (mem_req_o) begin
            if (prev_wait) begin
                checks++;
                if ({mem_addr_o, mem_wdata_o, mem_be_o} !== prev_bus) begin
                    errors++;
                    $display("FAIL bus_stable got %h want %h", {mem_addr_o, mem_wdata_o, mem_be_o}, prev_bus);
                end
            end
            prev_bus  = {mem_addr_o, mem_wdata_o, mem_be_o};
            prev_wait = !mem_ready_i;
            if (mem_ready_i) begin
                checks++;
                if (xfer_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_xfer unexpected we=%b addr=%h be=%h", mem_we_o, mem_addr_o, mem_be_o);
                end else begin
                    resp_exp = xfer_q.pop_front();
                    if ({mem_we_o, mem_addr_o, mem_be_o} !== resp_exp) begin
                        errors++;
                        $display("FAIL mem_xfer got %h want %h", {mem_we_o, mem_addr_o, mem_be_o}, resp_exp);
                    end
                end
                if (mem_we_o) begin
                    resp_w = mem_rd(mem_addr_o);
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be_o[b]) resp_w[8*b +: 8] = mem_wdata_o[8*b +: 8];
                    end
                    mem_m[mem_addr_o] = resp_w;
                end
            end
        end else begin
            prev_wait = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic go_idle();
        @(negedge clk);
        req_i = 1'b0;
        we_i  = 1'b0;
        #2;
    endtask

    task automatic do_load(input logic [31:0] a, input bit miss, output logic [31:0] got);
        int cyc;
        logic [31:0] exp;
        @(negedge clk);
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = a;
        rd_q.push_back(mem_rd({a[31:2], 2'b00}));
        if (miss) begin
            for (int i = 0; i < 4; i++) xfer_q.push_back({1'b0, a[31:4], 2'(i), 2'b00, 4'hF});
        end
        #2;
        cyc = 0;
        while (stall_o !== 1'b0 && cyc < 200) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("FAIL load_timeout addr=%h got stall want release", a);
        end
        exp = rd_q.pop_front();
        checks++;
        if (rdata_o !== exp) begin
            errors++;
            $display("FAIL load_data addr=%h got %h want %h", a, rdata_o, exp);
        end
        if (!rand_ready) begin
            checks++;
            if (cyc != (miss ? 5 : 0)) begin
                errors++;
                $display("FAIL load_stall addr=%h got %0d want %0d", a, cyc, miss ? 5 : 0);
            end
        end
        checks++;
        if (xfer_q.size() != 0) begin
            errors++;
            $display("FAIL load_beats addr=%h got %0d left want 0", a, xfer_q.size());
        end
        got = rdata_o;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int cyc;
        @(negedge clk);
        req_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = a;
        wdata_i = d;
        be_i    = be;
        xfer_q.push_back({1'b1, a[31:2], 2'b00, be});
        #2;
        cyc = 0;
        while (stall_o !== 1'b0 && cyc < 200) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        checks++;
        if (cyc >= 200 || xfer_q.size() != 0) begin
            errors++;
            $display("FAIL store addr=%h got cyc=%0d left=%0d want one write beat", a, cyc, xfer_q.size());
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        #2;
        checks++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b stall=%b want 0 0", mem_req_o, stall_o);
        end
        checks++;
        if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters got %0d %0d want 0 0", hit_cnt_o, miss_cnt_o);
        end
    endtask

    task automatic test_refill();
        logic [31:0] got;
        do_load(32'h0000_0100, 1'b1, got);
        checks++;
        if (miss_cnt_o !== 32'd1 || hit_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL refill_counters got hit=%0d miss=%0d want 0 1", hit_cnt_o, miss_cnt_o);
        end
        go_idle();
        checks++;
        if (hit_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL replay_not_counted got %0d want 0", hit_cnt_o);
        end
    endtask

    task automatic test_hit();
        logic [31:0] got;
        do_load(32'h0000_0104, 1'b0, got);
        go_idle();
        checks++;
        if (hit_cnt_o !== 32'd1 || miss_cnt_o !== 32'd1) begin
            errors++;
            $display("FAIL hit_counters got hit=%0d miss=%0d want 1 1", hit_cnt_o, miss_cnt_o);
        end
    endtask

    task automatic test_store_hit();
        logic [31:0] orig;
        logic [31:0] got;
        orig = mem_rd(32'h0000_0108);
        do_store(32'h0000_0108, 32'hAABB_CCDD, 4'b0011);
        do_load(32'h0000_0108, 1'b0, got);
        checks++;
        if (got !== {orig[31:16], 16'hCCDD}) begin
            errors++;
            $display("FAIL store_merge got %h want %h", got, {orig[31:16], 16'hCCDD});
        end
        go_idle();
        checks++;
        if (hit_cnt_o !== 32'd2 || miss_cnt_o !== 32'd1) begin
            errors++;
            $display("FAIL store_counters got hit=%0d miss=%0d want 2 1", hit_cnt_o, miss_cnt_o);
        end
    endtask

    task automatic test_store_miss();
        logic [31:0] got;
        do_store(32'h0000_0400, 32'h1234_5678, 4'hF);
        do_load(32'h0000_0400, 1'b1, got);
        checks++;
        if (got !== 32'h1234_5678) begin
            errors++;
            $display("FAIL store_miss_data got %h want 12345678", got);
        end
        go_idle();
        checks++;
        if (miss_cnt_o !== 32'd2) begin
            errors++;
            $display("FAIL store_miss_counter got %0d want 2", miss_cnt_o);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] got;
        do_load(32'h0000_0100, 1'b1, got);
        do_load(32'h0000_0200, 1'b1, got);
        do_load(32'h0000_0100, 1'b1, got);
        go_idle();
        checks++;
        if (miss_cnt_o !== 32'd5 || hit_cnt_o !== 32'd2) begin
            errors++;
            $display("FAIL conflict_counters got hit=%0d miss=%0d want 2 5", hit_cnt_o, miss_cnt_o);
        end
    endtask

    task automatic test_reset_mid_refill();
        rand_ready = 1'b1;
        @(negedge clk);
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = 32'h0000_0300;
        for (int i = 0; i < 4; i++) xfer_q.push_back({1'b0, 28'h000_0030, 2'(i), 2'b00, 4'hF});
        @(negedge clk);
        #2;
        checks++;
        if (stall_o !== 1'b1 || mem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_refill got stall=%b req=%b want 1 1", stall_o, mem_req_o);
        end
        @(negedge clk);
        rst_i = 1'b1;
        xfer_q.delete();
        @(negedge clk);
        rst_i = 1'b0;
        req_i = 1'b0;
        #2;
        checks++;
        if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got hit=%0d miss=%0d req=%b want 0 0 0", hit_cnt_o, miss_cnt_o, mem_req_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        do_load(32'h0000_0300, 1'b1, got);
        checks++;
        if (miss_cnt_o !== 32'd1) begin
            errors++;
            $display("FAIL post_reset_miss got %0d want 1", miss_cnt_o);
        end
        do_load(32'h0000_0300, 1'b0, got);
        do_load(32'h0000_030C, 1'b0, got);
        go_idle();
        checks++;
        if (hit_cnt_o !== 32'd2 || miss_cnt_o !== 32'd1) begin
            errors++;
            $display("FAIL back_to_back got hit=%0d miss=%0d want 2 1", hit_cnt_o, miss_cnt_o);
        end
        rand_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_refill();
        test_hit();
        test_store_hit();
        test_store_miss();
        test_conflict();
        test_reset_mid_refill();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
